// File: rtl/uart_pkg.sv
// Shared UART definitions for receiver and transmitter: FSM states,
// oversampling constants and an even-parity helper.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_SAMPLE = 7;
  localparam int unsigned DATA_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; dout always shows the head entry.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             do_pop_s;
  logic             do_push_s;

  assign empty    = (wr_ptr_r == rd_ptr_r);
  assign full     = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
  assign do_pop_s = pop && !empty;
  // A full FIFO still takes a write when a pop frees the head slot this cycle.
  assign do_push_s = push && (!full || do_pop_s);
  assign dout      = mem_r[rd_ptr_r[AW-1:0]];

  // Read/write pointer update
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end
  end

  // Storage array, contents intentionally not reset
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver: 16x oversampled deframer feeding a FWFT byte FIFO.
// Define UART_RX_PARITY_EN for 8E1 framing with an o_perr pulse; default is 8N1.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_baud,
  input  logic       i_rx,
  input  logic       i_read,
  output logic       o_ready,
  output logic [7:0] o_D,
  output logic       o_used,
  output logic       o_ferr,
`ifdef UART_RX_PARITY_EN
  output logic       o_perr,
`endif
  output logic       o_ovf
);

  localparam logic [3:0] TICK_MID  = 4'(MID_SAMPLE);
  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
  localparam uart_state_e AFTER_DATA = ST_PARITY;
`else
  localparam uart_state_e AFTER_DATA = ST_STOP;
`endif

  uart_state_e          state_r;
  uart_state_e          state_nxt_s;
  logic                 sync1_r;
  logic                 sync2_r;
  logic                 rx_prev_r;
  logic [3:0]           tick_cnt_r;
  logic [2:0]           bit_idx_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 fall_s;
  logic                 sample_s;
  logic                 clr_cnt_s;
  logic                 shift_en_s;
  logic                 push_s;
  logic                 ferr_s;
  logic                 perr_hold_s;
  logic                 push_r;
  logic                 ferr_r;
  logic                 ovf_r;
  logic                 fifo_empty_s;
  logic                 fifo_full_s;

  // Two-stage synchronizer plus a delayed copy for falling-edge detection
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_r   <= 1'b1;
      sync2_r   <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      sync1_r   <= i_rx;
      sync2_r   <= sync1_r;
      rx_prev_r <= sync2_r;
    end
  end

  // Only a high-to-low transition arms the receiver, so a held break stays idle.
  assign fall_s   = rx_prev_r & ~sync2_r;
  assign sample_s = i_baud && (tick_cnt_r == ((state_r == ST_START) ? TICK_MID : TICK_LAST));

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_r <= ST_IDLE;
    else       state_r <= state_nxt_s;
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (fall_s) state_nxt_s = ST_START;
        else        state_nxt_s = ST_IDLE;
      end
      ST_START: begin
        if (sample_s) state_nxt_s = sync2_r ? ST_IDLE : ST_DATA;
        else          state_nxt_s = ST_START;
      end
      ST_DATA: begin
        if (sample_s && (bit_idx_r == BIT_LAST)) state_nxt_s = AFTER_DATA;
        else                                     state_nxt_s = ST_DATA;
      end
      ST_PARITY: begin
        if (sample_s) state_nxt_s = ST_STOP;
        else          state_nxt_s = ST_PARITY;
      end
      ST_STOP: begin
        if (sample_s) state_nxt_s = ST_IDLE;
        else          state_nxt_s = ST_STOP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Per-state datapath controls and frame verdicts
  always_comb begin
    clr_cnt_s  = 1'b0;
    shift_en_s = 1'b0;
    push_s     = 1'b0;
    ferr_s     = 1'b0;
    case (state_r)
      ST_IDLE:   clr_cnt_s  = 1'b1;
      ST_START:  clr_cnt_s  = sample_s;
      ST_DATA:   shift_en_s = sample_s;
      ST_PARITY: clr_cnt_s  = 1'b0;
      ST_STOP: begin
        push_s = sample_s && sync2_r && !perr_hold_s;
        ferr_s = sample_s && !sync2_r;
      end
      default:   clr_cnt_s  = 1'b1;
    endcase
  end

  // Tick counter, bit index and LSB-first shift register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tick_cnt_r <= 4'd0;
      bit_idx_r  <= 3'd0;
      shift_r    <= '0;
    end else begin
      if (clr_cnt_s)   tick_cnt_r <= 4'd0;
      else if (i_baud) tick_cnt_r <= tick_cnt_r + 4'd1;
      if ((state_r == ST_START) && sample_s) bit_idx_r <= 3'd0;
      else if (shift_en_s)                   bit_idx_r <= bit_idx_r + 3'd1;
      if (shift_en_s) shift_r <= {sync2_r, shift_r[DATA_BITS-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  logic perr_flag_r;
  logic perr_r;

  // Parity verdict held until the stop bit, then reported as a pulse
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      perr_flag_r <= 1'b0;
      perr_r      <= 1'b0;
    end else begin
      if ((state_r == ST_PARITY) && sample_s) perr_flag_r <= even_parity(shift_r) ^ sync2_r;
      else if (state_r == ST_IDLE)            perr_flag_r <= 1'b0;
      perr_r <= (state_r == ST_STOP) && sample_s && perr_flag_r;
    end
  end

  assign perr_hold_s = perr_flag_r;
  assign o_perr      = perr_r;
`else
  assign perr_hold_s = 1'b0;
`endif

  // Push/error pulses land one cycle after the stop sample; overflow is sticky
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      push_r <= 1'b0;
      ferr_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      push_r <= push_s;
      ferr_r <= ferr_s;
      if (push_r && fifo_full_s && !i_read) ovf_r <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (push_r),
    .pop   (i_read),
    .din   (shift_r),
    .dout  (o_D),
    .empty (fifo_empty_s),
    .full  (fifo_full_s)
  );

  assign o_ready = ~fifo_empty_s;
  assign o_used  = (state_r != ST_IDLE);
  assign o_ferr  = ferr_r;
  assign o_ovf   = ovf_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: framed bytes are driven on i_rx, the expected FIFO
// contents live in a queue, and a monitor checks every pop against it.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_baud;
  logic       i_rx;
  logic       i_read;
  logic       o_ready;
  logic [7:0] o_D;
  logic       o_used;
  logic       o_ferr;
  logic       o_ovf;
`ifdef UART_RX_PARITY_EN
  logic       o_perr;
`endif

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_baud  (i_baud),
    .i_rx    (i_rx),
    .i_read  (i_read),
    .o_ready (o_ready),
    .o_D     (o_D),
    .o_used  (o_used),
    .o_ferr  (o_ferr),
`ifdef UART_RX_PARITY_EN
    .o_perr  (o_perr),
`endif
    .o_ovf   (o_ovf)
  );

  int         n_checks  = 0;
  int         n_pass    = 0;
  int         cyc       = 0;
  int         div       = 1;
  int         pop_at    = -1;
  bit         drain_en  = 1'b0;
  logic [7:0] exp_q[$];
  bit         exp_ovf   = 1'b0;
  int         exp_ferr  = 0;
  int         exp_perr  = 0;
  int         ferr_seen = 0;
  int         perr_seen = 0;
  int         pops      = 0;
  int         start_cyc = 0;
  int         rise_cyc  = -1;
  int         latency   = 0;
  bit         prev_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Baud tick generator: one tick every div cycles (div=1 holds it high)
  initial begin
    int ph = 0;
    i_baud = 1'b0;
    forever begin
      @(posedge clk); #1;
      i_baud = (ph == 0);
      ph = (ph + 1 >= div) ? 0 : ph + 1;
    end
  end

  // Reader: drains when enabled, or pops once at a scheduled cycle
  initial begin
    i_read = 1'b0;
    forever begin
      @(posedge clk); #1;
      i_read = (cyc == pop_at) || (drain_en && o_ready && !i_read && !i_rst);
    end
  end

  // Monitor: every accepted pop is compared with the scoreboard head
  initial begin
    forever begin
      @(negedge clk);
      if (!i_rst) begin
        if (o_ferr) ferr_seen++;
`ifdef UART_RX_PARITY_EN
        if (o_perr) perr_seen++;
`endif
        if (o_ready && !prev_ready && rise_cyc < 0) rise_cyc = cyc;
        if (i_read && o_ready) begin
          pops++;
          check("pop_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) check("pop_data", 32'(o_D), 32'(exp_q.pop_front()));
        end
      end
      prev_ready = o_ready;
    end
  end

  // Reference model: what a complete frame should do to the FIFO and flags
  task automatic model_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok,
                             input bit coinc);
    if (!par_ok)  exp_perr++;
    if (!stop_ok) exp_ferr++;
    if (stop_ok && par_ok) begin
      if (exp_q.size() < DEPTH || coinc) exp_q.push_back(b);
      else exp_ovf = 1'b1;
    end
  endtask

  task automatic wait_ticks(input int n);
    int c = 0;
    while (c < n) begin
      @(posedge clk);
      if (i_baud) c++;
    end
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok,
                            input bit coinc);
    @(posedge clk); #1;
    i_rx = 1'b0;
    start_cyc = cyc;
    if (coinc) pop_at = start_cyc + latency - 1;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      wait_ticks(16);
    end
`ifdef UART_RX_PARITY_EN
    i_rx = (^b) ^ !par_ok;
    wait_ticks(16);
`endif
    check("used_midframe", 32'(o_used), 1);
    i_rx = stop_ok;
    model_frame(b, stop_ok, par_ok, coinc);
    wait_ticks(16);
    i_rx = 1'b1;
    wait_ticks(2);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    i_rst = 1'b1;
    i_rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    i_rst = 1'b0;
    exp_q.delete();
    exp_ovf   = 1'b0;
    exp_ferr  = 0;
    exp_perr  = 0;
    ferr_seen = 0;
    perr_seen = 0;
    pops      = 0;
  endtask

  task automatic wait_drained(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || o_ready) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, 32'(n < 3000), 1);
  endtask

  initial begin
    logic [7:0] b;
    bit         s_ok;
    bit         p_ok;
    i_rst = 1'b1;
    i_rx  = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    i_rst = 1'b0;
    check("rst_ready", 32'(o_ready), 0);
    check("rst_used",  32'(o_used), 0);
    check("rst_ferr",  32'(o_ferr), 0);
    check("rst_ovf",   32'(o_ovf), 0);
`ifdef UART_RX_PARITY_EN
    check("rst_perr",  32'(o_perr), 0);
`endif

    // Pop on an empty FIFO must be ignored
    pop_at = cyc + 2;
    repeat (6) @(posedge clk);
    #1;
    pop_at = -1;
    check("empty_pop_ready", 32'(o_ready), 0);

    // First byte with i_baud held high
    div = 1;
    drain_en = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    wait_drained("a5_drain");
    latency = rise_cyc - start_cyc;
    check("a5_latency_window", 32'(latency >= 150 && latency <= 170), 1);
    check("a5_pops", 32'(pops), 1);

    // Short low glitch is rejected
    @(posedge clk); #1;
    i_rx = 1'b0;
    wait_ticks(4);
    i_rx = 1'b1;
    check("glitch_used", 32'(o_used), 1);
    wait_ticks(40);
    check("glitch_used_clear", 32'(o_used), 0);
    check("glitch_ferr", 32'(ferr_seen), 32'(exp_ferr));
    check("glitch_ready", 32'(o_ready), 0);

    // Bad stop bit, then a good byte
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    wait_ticks(20);
    check("badstop_ferr", 32'(ferr_seen), 32'(exp_ferr));
    check("badstop_ready", 32'(o_ready), 0);
    send_frame(8'h11, 1'b1, 1'b1, 1'b0);
    wait_drained("after_ferr_drain");

    // Held break: one framing error, then silence until the line recovers
    @(posedge clk); #1;
    i_rx = 1'b0;
    wait_ticks(400);
    i_rx = 1'b1;
    exp_ferr++;
    wait_ticks(40);
    check("break_ferr", 32'(ferr_seen), 32'(exp_ferr));
    check("break_ready", 32'(o_ready), 0);
    check("break_used", 32'(o_used), 0);
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    wait_drained("after_break_drain");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    wait_ticks(20);
    check("parity_bad_perr", 32'(perr_seen), 32'(exp_perr));
    check("parity_bad_ready", 32'(o_ready), 0);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    wait_drained("parity_good_drain");
`endif

    // Random bytes at random baud rates, occasional bad stop bits
    for (int i = 0; i < 24; i++) begin
      div  = int'($urandom_range(1, 4));
      b    = 8'($urandom);
      s_ok = ($urandom_range(0, 7) != 0);
`ifdef UART_RX_PARITY_EN
      p_ok = ($urandom_range(0, 7) != 0);
`else
      p_ok = 1'b1;
`endif
      send_frame(b, s_ok, p_ok, 1'b0);
    end
    wait_drained("random_drain");
    check("random_ferr", 32'(ferr_seen), 32'(exp_ferr));
    check("random_perr", 32'(perr_seen), 32'(exp_perr));
    check("random_ovf", 32'(o_ovf), 32'(exp_ovf));

    // Reset mid-frame abandons the partial byte
    div = 1;
    @(posedge clk); #1;
    i_rx = 1'b0;
    wait_ticks(70);
    do_reset();
    check("midrst_used", 32'(o_used), 0);
    wait_ticks(200);
    check("midrst_ready", 32'(o_ready), 0);
    check("midrst_ferr", 32'(ferr_seen), 0);

    // Overflow: 17 bytes into 16 entries, no reads
    drain_en = 1'b0;
    for (int i = 0; i <= DEPTH; i++) send_frame(8'(i), 1'b1, 1'b1, 1'b0);
    wait_ticks(20);
    check("ovf_set", 32'(o_ovf), 32'(exp_ovf));
    check("ovf_full_ready", 32'(o_ready), 1);
    pops = 0;
    drain_en = 1'b1;
    wait_drained("ovf_drain");
    check("ovf_pops", 32'(pops), DEPTH);
    check("ovf_sticky", 32'(o_ovf), 32'(exp_ovf));

    // Full FIFO with push and pop in the same cycle
    do_reset();
    check("reset_clears_ovf", 32'(o_ovf), 0);
    drain_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom), 1'b1, 1'b1, 1'b0);
    check("coinc_full_ready", 32'(o_ready), 1);
    send_frame(8'hE7, 1'b1, 1'b1, 1'b1);
    pop_at = -1;
    wait_ticks(20);
    check("coinc_ovf", 32'(o_ovf), 32'(exp_ovf));
    check("coinc_one_pop", 32'(pops), 1);
    drain_en = 1'b1;
    wait_drained("coinc_drain");
    check("coinc_total_pops", 32'(pops), DEPTH + 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #(800_000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
